dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the RISC-V core: the far end of the decoder's memory-access controls. It accepts the `mem_read`/`mem_write` request level, the ALU-computed address, the store data and `funct3` from the datapath. It then performs byte, half or word accesses on an internal word array after a configurable latency, and returns sign- or zero-extended load data with a one-cycle completion pulse. It sits between the execute stage and write-back, and is the DUT for the memory UVM environment.

## Interface
- `DEPTH`, 256: number of 32-bit words; must be a power of two.
- `LATENCY`, 2: cycles spent in ACCESS; must be ≥1.
- `i_clk` input 1: the single clock.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_mem_read` input 1: load request level.
- `i_mem_write` input 1: store request level.
- `i_addr` input 32: byte address.
- `i_wdata` input 32: store data, right-aligned.
- `i_funct3` input 3: access size and signedness.
- `o_rdata` output 32: extended load data; valid while `o_done`.
- `o_done` output 1: transaction complete, one cycle.
- `o_busy` output 1: high whenever the state is not IDLE.
- `o_fault` output 1: access rejected, qualified by `o_done`. Only exists in behaviour when `DMEM_MISALIGN_TRAP_EN` is defined; otherwise tied 0.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE → ACCESS when `i_mem_read | i_mem_write`.
  - On this edge, capture op, address, wdata and funct3.
  - Later input changes are ignored until the next accept.
- If both read and write are asserted, the transaction is a store; the read is ignored.
- ACCESS: a down-counter is loaded with `LATENCY-1` and decrements each cycle.
- ACCESS → RESP at counter 0. On this edge:
  - a store updates the addressed byte lanes only;
  - a load registers the extended data into `o_rdata`.
- RESP: `o_done`=1, then unconditionally return to IDLE.
- The initiator holds its request until it samples `o_done`, then drops it or presents the next request.
- A request still asserted in the IDLE cycle after RESP is a new transaction.
- Word index is `addr[log2(DEPTH)+1:2]`. Upper bits are ignored, so addresses wrap modulo `4*DEPTH`.
- Byte lane is selected by `addr[1:0]`.
- Loads:
  - 000 LB: sign-extend byte;
  - 001 LH: sign-extend half;
  - 010 LW: word;
  - 100 LBU: zero-extend byte;
  - 101 LHU: zero-extend half.
- Stores: 000 SB, 001 SH, 010 SW. Data comes from `i_wdata[7:0]`, `[15:0]` or `[31:0]` respectively.
- Reserved funct3 (011, 110, 111) is executed as a word access.
- `o_rdata` holds its last value outside RESP; a store leaves it unchanged.

## Timing
- Reset values: state IDLE, counter 0, `o_rdata`=0, `o_done`=0, `o_busy`=0, `o_fault`=0.
- The memory array is not reset.
- Latency: a request first sampled in IDLE at cycle N gives `o_done` high in cycle N+LATENCY+1.
  - LATENCY=1 → 2 cycles.
- `o_busy` rises the cycle after accept and falls on exit from RESP.
- Peak throughput is one transaction per LATENCY+2 cycles.
- Reset asserted mid-transaction aborts it immediately: no write occurs and no `o_done` is issued.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A transaction is faulting when it is misaligned (half with `addr[0]`=1; word with `addr[1:0]`≠0) or uses a reserved funct3.
  - A faulting transaction runs the same timing and raises `o_fault` with `o_done`.
  - Memory is not modified and `o_rdata` is unchanged.
- Undefined:
  - The offending low address bits are forced to zero: half aligns to `addr[1]`, word to `addr[1:0]`=0.
  - Reserved funct3 is treated as word; `o_fault` is constant 0.

## Structure
- Package `riscv_definitions` gains:
  - `mem_size_e` for the funct3 encodings (`MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`);
  - `dmem_state_e` (IDLE, ACCESS, RESP).
- One combinational sub-module, `dmem_lane_align`, handles both directions:
  - from funct3 and `addr[1:0]`, produces the 4-bit byte-enable and the lane-shifted write data;
  - extracts and extends the read data.
- The FSM, counter, capture registers and array live in the top level.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → `o_rdata`=0xDEADBEEF; `o_done` appears exactly LATENCY+1 cycles after each request; `o_busy` is high in between.
- SB 0x80 to 0x13, then:
  - LB 0x13 → 0xFFFFFF80;
  - LBU 0x13 → 0x00000080;
  - LW 0x10 → 0x80ADBEEF.
- SH 0xBEEF to 0x11:
  - with the macro, `o_fault`=1 and LW 0x10 is unchanged;
  - without it, LHU 0x10 → 0x0000BEEF.
- Read and write both asserted with 0x12345678 at 0x20, then LW 0x20 → 0x12345678; `o_rdata` is unchanged after the store.
- Reset pulsed during ACCESS of SW 0xFFFFFFFF to 0x30, then LW 0x30 → prior contents; `o_done` is not seen before reset.
- DEPTH=256: SW 0xA5A5A5A5 to 0x400, then LW 0x0 → 0xA5A5A5A5. The request is held across `o_done`, so the next transaction is accepted in the following IDLE cycle.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: funct3 access sizes, FSM states
// and the captured request record.
package riscv_definitions;
   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  funct3;
   } dmem_req_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the datapath (master) and dmem_responder (slave).
interface dmem_responder_if;
   logic        i_mem_read;
   logic        i_mem_write;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [2:0]  i_funct3;
   logic [31:0] o_rdata;
   logic        o_done;
   logic        o_busy;
   logic        o_fault;

   modport master (output i_mem_read, i_mem_write, i_addr, i_wdata, i_funct3,
                   input  o_rdata, o_done, o_busy, o_fault);
   modport slave  (input  i_mem_read, i_mem_write, i_addr, i_wdata, i_funct3,
                   output o_rdata, o_done, o_busy, o_fault);
endinterface

// File: rtl/dmem_responder_lane_align.sv
// dmem_lane_align: byte-enable / write-lane shift and load extraction/extension.
// DMEM_MISALIGN_TRAP_EN enables fault reporting for misaligned or reserved accesses.
module dmem_lane_align
   import riscv_definitions::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        fault_o
);
   logic       is_b, is_h, sgn;
   logic [1:0] off;
   logic [7:0] rb;
   logic [15:0] rh;

   always_comb begin
      is_b = 1'b0;
      is_h = 1'b0;
      sgn  = 1'b0;
      case (funct3_i)
         MEM_B:  begin is_b = 1'b1; sgn = 1'b1; end
         MEM_BU: is_b = 1'b1;
         MEM_H:  begin is_h = 1'b1; sgn = 1'b1; end
         MEM_HU: is_h = 1'b1;
         default: ;
      endcase
      // Misaligned halves/words collapse onto their natural boundary.
      off     = is_b ? addr_lo_i : (is_h ? {addr_lo_i[1], 1'b0} : 2'b00);
      be_o    = is_b ? (4'b0001 << off) : (is_h ? (4'b0011 << off) : 4'b1111);
      wdata_o = wdata_i << {off, 3'b000};
      rb      = rword_i[{off, 3'b000} +: 8];
      rh      = rword_i[{off[1], 4'b0000} +: 16];
      rdata_o = is_b ? {{24{sgn & rb[7]}}, rb}
              : (is_h ? {{16{sgn & rh[15]}}, rh} : rword_i);
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   assign fault_o = (funct3_i inside {3'b011, 3'b110, 3'b111})
                  | (is_h & addr_lo_i[0])
                  | (!is_b && !is_h && (addr_lo_i != 2'b00));
`else
   assign fault_o = 1'b0;
`endif
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/ACCESS/RESP FSM, latency counter, request capture
// and word array. DMEM_MISALIGN_TRAP_EN turns rejected accesses into o_fault.
module dmem_responder
   import riscv_definitions::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input logic             i_clk,
   input logic             i_rst_n,
   dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmem_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   dmem_req_t     req_q, req_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   mem_q [DEPTH];

   logic          accept, fin, fault;
   logic [3:0]    be;
   logic [31:0]   wsh, rext, rword;
   logic [AW-1:0] widx;
   logic          unused_addr;

   assign accept      = (state_q == IDLE) && (bus.i_mem_read || bus.i_mem_write);
   assign fin         = (state_q == ACCESS) && (cnt_q == '0);
   assign widx        = req_q.addr[AW+1:2];
   assign rword       = mem_q[widx];
   assign unused_addr = ^req_q.addr[31:AW+2];

   dmem_lane_align u_align (
      .funct3_i  (req_q.funct3),
      .addr_lo_i (req_q.addr[1:0]),
      .wdata_i   (req_q.wdata),
      .rword_i   (rword),
      .be_o      (be),
      .wdata_o   (wsh),
      .rdata_o   (rext),
      .fault_o   (fault)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = ACCESS;
            cnt_d   = CW'(LATENCY - 1);
            // Write wins when both levels are up.
            req_d   = '{wr: bus.i_mem_write, addr: bus.i_addr,
                        wdata: bus.i_wdata, funct3: bus.i_funct3};
         end
         ACCESS: if (cnt_q == '0) begin
            state_d = RESP;
            if (!req_q.wr && !fault) rdata_d = rext;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.o_rdata = rdata_q;
      bus.o_done  = (state_q == RESP);
      bus.o_busy  = (state_q != IDLE);
      bus.o_fault = (state_q == RESP) && fault;
   end

   always_ff @(posedge i_clk) begin
      if (fin && req_q.wr && !fault)
         for (int b = 0; b < 4; b++)
            if (be[b]) mem_q[widx][b*8 +: 8] <= wsh[b*8 +: 8];
   end
endmodule
